// File: rtl/edge_detector_pkg.sv
// Shared constants and helpers for the edge detector block.
package edge_detector_pkg;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned SYNC_MAX      = 4;

    // Pick the strobe that drives cout for a given edge mode.
    function automatic logic sel_edge(input int unsigned mode, input logic r, input logic f);
        logic sel;
        unique case (mode)
            EDGE_FALL: sel = f;
            EDGE_BOTH: sel = r | f;
            default:   sel = r;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/edge_detector_if.sv
// Signal bundle between a level source and the edge detector.
// EDGE_DETECTOR_COUNT_EN adds the edge_cnt signal.
interface edge_detector_if #(
    parameter int unsigned CNT_W = edge_detector_pkg::CNT_W_DEFAULT
);
    logic cin;
    logic cout;
    logic rise;
    logic fall;

`ifdef EDGE_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] edge_cnt;

    modport master (output cin, input cout, input rise, input fall, input edge_cnt);
    modport slave  (input cin, output cout, output rise, output fall, output edge_cnt);
`else
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("edge_detector_if: CNT_W must be non-zero");
    end

    modport master (output cin, input cout, input rise, input fall);
    modport slave  (input cin, output cout, output rise, output fall);
`endif

endinterface

// File: rtl/edge_sync_chain.sv
// Flop chain used as a metastability synchronizer ahead of edge detection.
module edge_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    if (STAGES < 2) begin : g_bad_stages
        $error("edge_sync_chain: STAGES must be at least 2");
    end

    // Shift the input one stage further down the chain each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
    end

    // Chain register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/edge_detector.sv
// Registered edge detector: one-cycle pulses on rise, fall and the selected edge (cout).
// Optional edge counter on cout enabled by EDGE_DETECTOR_COUNT_EN.
module edge_detector
    import edge_detector_pkg::*;
#(
    parameter int unsigned EDGE_MODE   = EDGE_RISE,
    parameter int unsigned SYNC_STAGES = 0,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input logic           clk,
    input logic           rstn,
    edge_detector_if.slave bus
);

    // Priming waits for the synchronizer to fill so a reset-zeroed chain never looks like an edge.
    localparam logic [2:0] PrimeLast = 3'(SYNC_STAGES);

    logic cs;

    if (SYNC_STAGES == 1 || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("edge_detector: SYNC_STAGES must be 0 or 2..4");
    end
    if (EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
        $error("edge_detector: EDGE_MODE must be 0, 1 or 2");
    end

    if (SYNC_STAGES == 0) begin : g_direct
        assign cs = bus.cin;
    end else begin : g_sync
        edge_sync_chain #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rstn (rstn),
            .d_i  (bus.cin),
            .q_o  (cs)
        );
    end

    logic       smp_q, smp_d;
    logic       prev_q, prev_d;
    logic       primed_q, primed_d;
    logic [2:0] prime_cnt_q, prime_cnt_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       cout_q, cout_d;

    // Priming, history update and edge decode.
    always_comb begin
        smp_d       = cs;
        prev_d      = smp_q;
        primed_d    = primed_q;
        prime_cnt_d = prime_cnt_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        if (!primed_q) begin
            // Seed history with the current sample so no edge is seen out of reset.
            prev_d = cs;
            if (prime_cnt_q == PrimeLast) begin
                primed_d = 1'b1;
            end else begin
                prime_cnt_d = prime_cnt_q + 3'd1;
            end
        end else begin
            rise_d = smp_q & ~prev_q;
            fall_d = ~smp_q & prev_q;
        end
        cout_d = sel_edge(EDGE_MODE, rise_d, fall_d);
    end

    // Sample, history and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            smp_q       <= 1'b0;
            prev_q      <= 1'b0;
            primed_q    <= 1'b0;
            prime_cnt_q <= 3'd0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            smp_q       <= smp_d;
            prev_q      <= prev_d;
            primed_q    <= primed_d;
            prime_cnt_q <= prime_cnt_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            cout_q      <= cout_d;
        end
    end

    assign bus.cout = cout_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;

`ifdef EDGE_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of cout pulses; updates alongside cout.
    always_comb begin
        cnt_d = cnt_q;
        if (cout_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.edge_cnt = cnt_q;
`else
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("edge_detector: CNT_W must be non-zero");
    end
`endif

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector: four configurations share cin/rstn and are compared
// every cycle against a sample-history model; directed scenarios add literal expectations.
// Honours EDGE_DETECTOR_COUNT_EN.
module tb_edge_detector;
    import edge_detector_pkg::*;

    localparam int unsigned CW   = 16;
    localparam int          NDUT = 4;
    localparam int MODE [NDUT] = '{0, 1, 2, 0};
    localparam int SYNC [NDUT] = '{0, 0, 0, 2};

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic cin  = 1'b1;

    always #5 clk = ~clk;

    edge_detector_if #(.CNT_W(CW)) if0 ();
    edge_detector_if #(.CNT_W(CW)) if1 ();
    edge_detector_if #(.CNT_W(CW)) if2 ();
    edge_detector_if #(.CNT_W(CW)) if3 ();

    assign if0.cin = cin;
    assign if1.cin = cin;
    assign if2.cin = cin;
    assign if3.cin = cin;

    edge_detector #(.EDGE_MODE(EDGE_RISE), .SYNC_STAGES(0), .CNT_W(CW)) u_dut0 (
        .clk (clk), .rstn (rstn), .bus (if0.slave)
    );
    edge_detector #(.EDGE_MODE(EDGE_FALL), .SYNC_STAGES(0), .CNT_W(CW)) u_dut1 (
        .clk (clk), .rstn (rstn), .bus (if1.slave)
    );
    edge_detector #(.EDGE_MODE(EDGE_BOTH), .SYNC_STAGES(0), .CNT_W(CW)) u_dut2 (
        .clk (clk), .rstn (rstn), .bus (if2.slave)
    );
    edge_detector #(.EDGE_MODE(EDGE_RISE), .SYNC_STAGES(2), .CNT_W(CW)) u_dut3 (
        .clk (clk), .rstn (rstn), .bus (if3.slave)
    );

    logic [NDUT-1:0] cout_v, rise_v, fall_v;
    assign cout_v = {if3.cout, if2.cout, if1.cout, if0.cout};
    assign rise_v = {if3.rise, if2.rise, if1.rise, if0.rise};
    assign fall_v = {if3.fall, if2.fall, if1.fall, if0.fall};

`ifdef EDGE_DETECTOR_COUNT_EN
    logic [CW-1:0] ecnt_v [NDUT];
    assign ecnt_v[0] = if0.edge_cnt;
    assign ecnt_v[1] = if1.edge_cnt;
    assign ecnt_v[2] = if2.edge_cnt;
    assign ecnt_v[3] = if3.edge_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Values seen by the DUT at each posedge.
    logic c_smp = 1'b0;
    logic r_smp = 1'b0;
    int   pe    = 0;

    always @(posedge clk) begin
        c_smp <= cin;
        r_smp <= rstn;
        pe    <= pe + 1;
    end

    // Model: after the j-th post-reset posedge, a pulse reflects the change between samples
    // j-2-S and j-1-S, and only once j >= S+2 (priming plus one compare cycle).
    bit          hist [$];
    int unsigned mcnt [NDUT];
    int          n_cout [NDUT], n_rise [NDUT], n_fall [NDUT];
    int          last_cout_pe [NDUT], last_fall_pe [NDUT];

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            mcnt[d] = 0; n_cout[d] = 0; n_rise[d] = 0; n_fall[d] = 0;
            last_cout_pe[d] = -1; last_fall_pe[d] = -1;
        end
    end

    always @(negedge clk) begin
        int   j;
        logic a, b, er, ef, ec;
        if (!r_smp) hist.delete();
        else        hist.push_back(c_smp);
        j = hist.size() - 1;
        for (int d = 0; d < NDUT; d++) begin
            er = 1'b0;
            ef = 1'b0;
            if (r_smp && j >= SYNC[d] + 2) begin
                a  = hist[j - 2 - SYNC[d]];
                b  = hist[j - 1 - SYNC[d]];
                er = b & ~a;
                ef = a & ~b;
            end
            ec = (MODE[d] == 0) ? er : (MODE[d] == 1) ? ef : (er | ef);
            if (!r_smp) mcnt[d] = 0;
            else if (ec && mcnt[d] != (2 ** CW - 1)) mcnt[d]++;
            check($sformatf("dut%0d.cout", d), 32'(cout_v[d]), 32'(ec));
            check($sformatf("dut%0d.rise", d), 32'(rise_v[d]), 32'(er));
            check($sformatf("dut%0d.fall", d), 32'(fall_v[d]), 32'(ef));
`ifdef EDGE_DETECTOR_COUNT_EN
            check($sformatf("dut%0d.edge_cnt", d), 32'(ecnt_v[d]), mcnt[d]);
`endif
            if (cout_v[d] === 1'b1) begin n_cout[d]++; last_cout_pe[d] = pe; end
            if (rise_v[d] === 1'b1) n_rise[d]++;
            if (fall_v[d] === 1'b1) begin n_fall[d]++; last_fall_pe[d] = pe; end
        end
    end

    int s_cout [NDUT], s_rise [NDUT], s_fall [NDUT];
    int chg_pe, glitch_pe, tot;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        #1;
        s_cout = n_cout;
        s_rise = n_rise;
        s_fall = n_fall;
    endtask

    initial begin
        // Reset with cin already high, then ten quiet cycles.
        tick(2);
        rstn = 1'b1;
        snap();
        tick(10);
        #1;
        tot = 0;
        for (int d = 0; d < NDUT; d++) begin
            tot += (n_cout[d] - s_cout[d]) + (n_rise[d] - s_rise[d]) + (n_fall[d] - s_fall[d]);
        end
        check("reset_high_quiet", 32'(tot), 0);

        // Single rising edge at 520 ns, held 1000 ns.
        cin = 1'b0;
        while ($time < 520) @(negedge clk);
        snap();
        cin    = 1'b1;
        chg_pe = pe;
        tick(100);
        #1;
        check("rise_cout_pulses", 32'(n_cout[0] - s_cout[0]), 1);
        check("rise_rise_pulses", 32'(n_rise[0] - s_rise[0]), 1);
        check("rise_fall_pulses", 32'(n_fall[0] - s_fall[0]), 0);
        check("rise_latency", 32'(last_cout_pe[0] - chg_pe), 2);
        check("fall_mode_quiet", 32'(n_cout[1] - s_cout[1]), 0);
        check("sync2_pulses", 32'(n_cout[3] - s_cout[3]), 1);
        check("sync2_latency", 32'(last_cout_pe[3] - chg_pe), 4);

        // One-cycle low glitch.
        tick(1);
        snap();
        cin       = 1'b0;
        glitch_pe = pe;
        tick(1);
        cin = 1'b1;
        tick(8);
        #1;
        check("glitch_cout_pulses", 32'(n_cout[0] - s_cout[0]), 1);
        check("glitch_fall_pulses", 32'(n_fall[0] - s_fall[0]), 1);
        check("glitch_fall_latency", 32'(last_fall_pe[0] - glitch_pe), 2);
        check("glitch_fall_before_rise", 32'(last_cout_pe[0] - last_fall_pe[0]), 1);

        // Both-edge mode from a fresh reset: 8 toggles, 3 cycles apart.
        tick(1);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(4);
        snap();
        repeat (8) begin
            cin = ~cin;
            tick(3);
        end
        tick(6);
        #1;
        check("both_cout_pulses", 32'(n_cout[2] - s_cout[2]), 8);
        check("both_rise_count", 32'(n_rise[0] - s_rise[0]), 4);
        check("both_fall_count", 32'(n_fall[0] - s_fall[0]), 4);
`ifdef EDGE_DETECTOR_COUNT_EN
        check("both_edge_cnt", 32'(ecnt_v[2]), 8);
`endif

        // Reset asserted the cycle after cin rises; pulse must be dropped.
        cin = 1'b0;
        tick(6);
        snap();
        cin = 1'b1;
        tick(1);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(10);
        #1;
        tot = 0;
        for (int d = 0; d < NDUT; d++) tot += n_cout[d] - s_cout[d];
        check("midreset_no_cout", 32'(tot), 0);
`ifdef EDGE_DETECTOR_COUNT_EN
        check("midreset_edge_cnt", 32'(ecnt_v[0]), 0);
`endif

        // Random cin activity with occasional single-cycle resets.
        repeat (3000) begin
            tick(1);
            if ($urandom_range(0, 2) == 0) cin = ~cin;
            rstn = ($urandom_range(0, 249) != 0);
        end
        rstn = 1'b1;
        tick(8);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
